// File: rtl/wheel_encoder_reader.sv
// Quadrature encoder reader: synchronizes and glitch-filters A/B, decodes x4
// Gray steps into a wrapping signed position, tracks last direction, flags
// illegal double-bit transitions and reports edges per fixed time window.
module wheel_encoder_reader #(
    parameter int CNT_W         = 16,
    parameter int SPEED_W       = 12,
    parameter int WINDOW_CYCLES = 1000000,
    parameter int FILT_LEN      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               clr_pos,
    output logic [CNT_W-1:0]   position,
    output logic               dir,
    output logic [SPEED_W-1:0] speed,
    output logic               speed_valid,
    output logic               step_err
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int FC_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [FC_W-1:0]    FILT_LAST = FC_W'(FILT_LEN - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

    // Channel bit 1 is A, bit 0 is B throughout.
    logic [1:0]               sync1_q, sync2_q;
    logic [1:0]               filt_q, filt_d;
    logic [1:0][FC_W-1:0]     fcnt_q, fcnt_d;
    logic [1:0]               prev_q, prev_d;
    logic                     primed_q, primed_d;
    logic [CNT_W-1:0]         pos_q, pos_d;
    logic                     dir_q, dir_d;
    logic                     err_q, err_d;
    logic [WIN_W-1:0]         win_q, win_d;
    logic [SPEED_W-1:0]       acc_q, acc_d;
    logic [SPEED_W-1:0]       speed_q, speed_d;
    logic                     vld_q, vld_d;

    logic                     is_fwd, is_rev, is_err;
    logic [SPEED_W-1:0]       acc_inc;

    // Successor of a Gray state in the forward direction 00->01->11->10->00.
    function automatic logic [1:0] gray_fwd(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Per-channel stability filter: a channel only moves after FILT_LEN
    // consecutive cycles of disagreement with its filtered value.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Step decode, position/direction update and windowed edge counting.
    always_comb begin
        is_fwd   = primed_q && (filt_q == gray_fwd(prev_q));
        is_rev   = primed_q && (prev_q == gray_fwd(filt_q));
        is_err   = primed_q && (filt_q == ~prev_q);
        prev_d   = filt_q;
        primed_d = 1'b1;
        err_d    = is_err;
        pos_d    = pos_q;
        dir_d    = dir_q;
        if (is_fwd) begin
            pos_d = pos_q + 1'b1;
            dir_d = 1'b1;
        end else if (is_rev) begin
            pos_d = pos_q - 1'b1;
            dir_d = 1'b0;
        end
        // Clear wins over a coincident step; that step still counts for dir/speed.
        if (clr_pos) begin
            pos_d = '0;
        end
        acc_inc = ((is_fwd || is_rev) && (acc_q != SPEED_MAX)) ? acc_q + 1'b1 : acc_q;
        speed_d = speed_q;
        vld_d   = 1'b0;
        if (win_q == WIN_LAST) begin
            win_d   = '0;
            acc_d   = '0;
            speed_d = acc_inc;
            vld_d   = 1'b1;
        end else begin
            win_d   = win_q + 1'b1;
            acc_d   = acc_inc;
        end
    end

    // State registers, all cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            filt_q   <= '0;
            fcnt_q   <= '0;
            prev_q   <= '0;
            primed_q <= 1'b0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            win_q    <= '0;
            acc_q    <= '0;
            speed_q  <= '0;
            vld_q    <= 1'b0;
        end else begin
            sync1_q  <= {enc_a, enc_b};
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            win_q    <= win_d;
            acc_q    <= acc_d;
            speed_q  <= speed_d;
            vld_q    <= vld_d;
        end
    end

    assign position    = pos_q;
    assign dir         = dir_q;
    assign speed       = speed_q;
    assign speed_valid = vld_q;
    assign step_err    = err_q;

endmodule
